cordic_ln_ctrl_fsm: RTL and testbench
=====================================

// Module: cordic_ln_ctrl_fsm
// PURPOSE
//  Sequencer driving the CORDIC natural-log datapath (Coprocesador_CORDIC): issues register enables,
//  mux selects and FP adder starts; consumes adder ACKs, flags and iteration count. One host job:
//  start -> init X=T*16+1, Y=T*16-1, Z=0 -> ITERS micro-rotations -> Z - ln16 -> RESULT reg -> ready.
// PARAMETERS
//  D        5    width of iteration count CONT_ITERA
//  ITERS    25   micro-rotations per job (1..2^D-1)
//  TIMEOUT  255  max cycles waiting on adder ACKs (used only with CORDIC_TIMEOUT_EN)
// PORTS
//  CLK         in   1  system clock
//  RST         in   1  synchronous, active-high reset
//  beg_FSM     in   1  host start; sampled only in IDLE
//  ack_FSM     in   1  host acknowledge of result; sampled only in DONE
//  ACK_SUMX/Y/Z in  1  FP adder completion (level or pulse; both accepted)
//  O_FX/Y/Z,U_FX/Y/Z in 1 adder overflow/underflow flags
//  CONT_ITERA  in   D  datapath iteration counter value
//  RST_DP      out  1  datapath-only reset (ORed with RST at top level)
//  MS_1,MS_2,MS_3 out 1 datapath mux selects
//  EN_REG1X/Y/Z,EN_REG2,EN_REG2XYZ,EN_REG3,EN_REG4 out 1 register enables
//  Begin_SUMX/Y/Z out 1 FP adder start pulses
//  ADD_SUBT    out  1  adder op; held 0 (add) - signs come from datapath
//  CLK_CDIR    out  1  iteration counter increment pulse
//  ready       out  1  result valid on RESULT
//  err         out  1  overflow/underflow (or timeout) occurred in this job
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; sticky ACK flags and err cleared.
//  - Moore outputs, registered state. Unlisted outputs are 0 in each state.
//  - IDLE: beg_FSM=1 -> START.   START: RST_DP=1 (clears counter/regs) -> LOAD.
//  - LOAD: EN_REG3=1 (T with exp+4) -> INIT_BEG.
//  - INIT_BEG: MS_2=1, Begin_SUMX=Begin_SUMY=1 (1 cycle) -> INIT_WAIT (MS_2=1 held).
//  - INIT_WAIT: until sticky X&Y ACK set -> INIT_LAT: MS_1=1, EN_REG1X/Y/Z=1 (Z0=0) -> LUT_WAIT.
//  - LUT_WAIT: 1 idle cycle (clocked LUT ROMs settle on new CONT_ITERA) -> CAP.
//  - CAP: EN_REG2=1, EN_REG2XYZ=1 -> ADD_BEG: Begin_SUMX/Y/Z=1, MS_2=MS_3=0 -> ADD_WAIT.
//  - ADD_WAIT: until sticky X&Y&Z ACK set -> ADD_LAT: EN_REG1X/Y/Z=1, MS_1=0 -> CNT.
//  - CNT: if CONT_ITERA==ITERS-1 -> FIN_BEG (no CLK_CDIR); else CLK_CDIR=1 -> LUT_WAIT.
//  - FIN_BEG: MS_3=1, Begin_SUMZ=1 -> FIN_WAIT (MS_3=1 held) until Z ACK -> FIN_LAT: EN_REG4=1 -> DONE.
//  - DONE: ready=1, err held; ack_FSM=1 -> IDLE (ready drops next cycle). beg_FSM ignored in DONE.
//  - Sticky ACK flags: cleared in every *_BEG state; set by ACK_SUMx=1 in *_WAIT; ACKs asserted
//    in the *_BEG cycle itself are ignored. ACKs arriving in different cycles are all accepted.
//  - err: set when any O_F*/U_F* is 1 in a *_WAIT cycle whose ACK is seen; job still completes;
//    cleared in START.
//  - Mux selects held constant from *_BEG through *_LAT of each operation.
//  - RST mid-job: IDLE next cycle, all outputs 0, no further adder starts.
//  - Latency (adder latency A cycles): 3 + (A+2) + ITERS*(A+5) + (A+2) cycles beg -> ready.
// CONFIGURATION
//  CORDIC_TIMEOUT_EN defined: 8-bit wait counter cleared in *_BEG, increments in *_WAIT; reaching
//   TIMEOUT -> err=1, EN_REG4 not pulsed, go to DONE. Undefined: waits indefinitely, no counter.
// TESTING
//  1 RST=1 2 cycles -> all outputs 0, state IDLE; beg_FSM during RST ignored.
//  2 Adder model A=4, ITERS=25, beg_FSM pulse -> Begin_SUMZ pulses 25+1, CLK_CDIR 24, EN_REG4 once,
//    ready at 3+6+225+6=240 cycles; ack_FSM -> ready 0, IDLE.
//  3 ACK_SUMX at +2, ACK_SUMY +5, ACK_SUMZ +3 (pulses) -> ADD_LAT only after cycle +5.
//  4 O_FY=1 with ACK_SUMY on iteration 10 -> err=1 at DONE, job completes; next job err=0.
//  5 RST asserted in ADD_WAIT of iteration 7 -> outputs 0 next cycle; fresh beg_FSM runs full job.
//  6 CORDIC_TIMEOUT_EN, TIMEOUT=255, ACK_SUMZ never asserted -> DONE with err=1 after 255 wait
//    cycles, EN_REG4 never asserted; without macro FSM stays in ADD_WAIT.

Source files
------------

// File: rtl/cordic_ln_ctrl_fsm.sv
// cordic_ln_ctrl_fsm: sequencer for the CORDIC natural-log datapath.
// Ports: CLK/RST (sync, active-high); host beg_FSM/ack_FSM -> ready/err;
//   adder ACK_SUM*/O_F*/U_F* in, Begin_SUM*/ADD_SUBT out; CONT_ITERA in,
//   CLK_CDIR out; RST_DP, MS_1..3 and EN_REG* datapath controls.
// Optional: define CORDIC_TIMEOUT_EN to bound every adder wait by TIMEOUT.
module cordic_ln_ctrl_fsm #(
  parameter int D     = 5,
  parameter int ITERS = 25
`ifdef CORDIC_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         beg_FSM,
  input  logic         ack_FSM,
  input  logic         ACK_SUMX,
  input  logic         ACK_SUMY,
  input  logic         ACK_SUMZ,
  input  logic         O_FX,
  input  logic         O_FY,
  input  logic         O_FZ,
  input  logic         U_FX,
  input  logic         U_FY,
  input  logic         U_FZ,
  input  logic [D-1:0] CONT_ITERA,
  output logic         RST_DP,
  output logic         MS_1,
  output logic         MS_2,
  output logic         MS_3,
  output logic         EN_REG1X,
  output logic         EN_REG1Y,
  output logic         EN_REG1Z,
  output logic         EN_REG2,
  output logic         EN_REG2XYZ,
  output logic         EN_REG3,
  output logic         EN_REG4,
  output logic         Begin_SUMX,
  output logic         Begin_SUMY,
  output logic         Begin_SUMZ,
  output logic         ADD_SUBT,
  output logic         CLK_CDIR,
  output logic         ready,
  output logic         err
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_LOAD      = 4'd2;
  localparam logic [3:0] S_INIT_BEG  = 4'd3;
  localparam logic [3:0] S_INIT_WAIT = 4'd4;
  localparam logic [3:0] S_INIT_LAT  = 4'd5;
  localparam logic [3:0] S_LUT_WAIT  = 4'd6;
  localparam logic [3:0] S_CAP       = 4'd7;
  localparam logic [3:0] S_ADD_BEG   = 4'd8;
  localparam logic [3:0] S_ADD_WAIT  = 4'd9;
  localparam logic [3:0] S_ADD_LAT   = 4'd10;
  localparam logic [3:0] S_CNT       = 4'd11;
  localparam logic [3:0] S_FIN_BEG   = 4'd12;
  localparam logic [3:0] S_FIN_WAIT  = 4'd13;
  localparam logic [3:0] S_FIN_LAT   = 4'd14;
  localparam logic [3:0] S_DONE      = 4'd15;

  localparam logic [D-1:0] LAST_IT = D'(ITERS - 1);

  logic [3:0] state_q, state_d;
  logic       ackx_q, ackx_d;
  logic       acky_q, acky_d;
  logic       ackz_q, ackz_d;
  logic       err_q, err_d;
  logic       tmo;

  // An ACK counts whether it is still high or was caught earlier.
  logic seen_x, seen_y, seen_z;
  logic errx, erry, errz;
  logic last;

  assign seen_x = ackx_q | ACK_SUMX;
  assign seen_y = acky_q | ACK_SUMY;
  assign seen_z = ackz_q | ACK_SUMZ;
  assign errx   = ACK_SUMX & (O_FX | U_FX);
  assign erry   = ACK_SUMY & (O_FY | U_FY);
  assign errz   = ACK_SUMZ & (O_FZ | U_FZ);
  assign last   = (CONT_ITERA == LAST_IT);

`ifdef CORDIC_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  assign tmo = (wait_q == 8'(TIMEOUT - 1));

  always_comb begin
    wait_d = wait_q;
    unique case (state_q)
      S_INIT_BEG, S_ADD_BEG, S_FIN_BEG:    wait_d = '0;
      S_INIT_WAIT, S_ADD_WAIT, S_FIN_WAIT: wait_d = wait_q + 8'd1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ackx_d  = ackx_q;
    acky_d  = acky_q;
    ackz_d  = ackz_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE:  if (beg_FSM) state_d = S_START;
      S_START: begin
        err_d   = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_INIT_BEG;
      S_INIT_BEG, S_ADD_BEG, S_FIN_BEG: begin
        ackx_d  = 1'b0;
        acky_d  = 1'b0;
        ackz_d  = 1'b0;
        state_d = state_q + 4'd1;
      end
      S_INIT_WAIT: begin
        ackx_d = seen_x;
        acky_d = seen_y;
        if (errx | erry) err_d = 1'b1;
        if (seen_x & seen_y) state_d = S_INIT_LAT;
        else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_INIT_LAT: state_d = S_LUT_WAIT;
      S_LUT_WAIT: state_d = S_CAP;
      S_CAP:      state_d = S_ADD_BEG;
      S_ADD_WAIT: begin
        ackx_d = seen_x;
        acky_d = seen_y;
        ackz_d = seen_z;
        if (errx | erry | errz) err_d = 1'b1;
        if (seen_x & seen_y & seen_z) state_d = S_ADD_LAT;
        else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_ADD_LAT: state_d = S_CNT;
      S_CNT:     state_d = last ? S_FIN_BEG : S_LUT_WAIT;
      S_FIN_WAIT: begin
        ackz_d = seen_z;
        if (errz) err_d = 1'b1;
        if (seen_z) state_d = S_FIN_LAT;
        else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_FIN_LAT: state_d = S_DONE;
      S_DONE:    if (ack_FSM) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ackx_q  <= 1'b0;
      acky_q  <= 1'b0;
      ackz_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ackx_q  <= ackx_d;
      acky_q  <= acky_d;
      ackz_q  <= ackz_d;
      err_q   <= err_d;
    end
  end

  // Mux selects stay stable from each *_BEG through its *_LAT.
  always_comb begin
    RST_DP     = 1'b0;
    MS_1       = 1'b0;
    MS_2       = 1'b0;
    MS_3       = 1'b0;
    EN_REG1X   = 1'b0;
    EN_REG1Y   = 1'b0;
    EN_REG1Z   = 1'b0;
    EN_REG2    = 1'b0;
    EN_REG2XYZ = 1'b0;
    EN_REG3    = 1'b0;
    EN_REG4    = 1'b0;
    Begin_SUMX = 1'b0;
    Begin_SUMY = 1'b0;
    Begin_SUMZ = 1'b0;
    CLK_CDIR   = 1'b0;
    ready      = 1'b0;
    unique case (state_q)
      S_START: RST_DP = 1'b1;
      S_LOAD:  EN_REG3 = 1'b1;
      S_INIT_BEG: begin
        MS_1       = 1'b1;
        MS_2       = 1'b1;
        Begin_SUMX = 1'b1;
        Begin_SUMY = 1'b1;
      end
      S_INIT_WAIT: begin
        MS_1 = 1'b1;
        MS_2 = 1'b1;
      end
      S_INIT_LAT: begin
        MS_1     = 1'b1;
        MS_2     = 1'b1;
        EN_REG1X = 1'b1;
        EN_REG1Y = 1'b1;
        EN_REG1Z = 1'b1;
      end
      S_CAP: begin
        EN_REG2    = 1'b1;
        EN_REG2XYZ = 1'b1;
      end
      S_ADD_BEG: begin
        Begin_SUMX = 1'b1;
        Begin_SUMY = 1'b1;
        Begin_SUMZ = 1'b1;
      end
      S_ADD_LAT: begin
        EN_REG1X = 1'b1;
        EN_REG1Y = 1'b1;
        EN_REG1Z = 1'b1;
      end
      S_CNT: CLK_CDIR = ~last;
      S_FIN_BEG: begin
        MS_3       = 1'b1;
        Begin_SUMZ = 1'b1;
      end
      S_FIN_WAIT: MS_3 = 1'b1;
      S_FIN_LAT: begin
        MS_3    = 1'b1;
        EN_REG4 = 1'b1;
      end
      S_DONE:  ready = 1'b1;
      default: ;
    endcase
  end

  assign ADD_SUBT = 1'b0;
  assign err      = err_q;

endmodule

// File: tb/tb_cordic_ln_ctrl_fsm.sv
// tb_cordic_ln_ctrl_fsm: directed and randomized jobs against a latency /
// event-count model, with a simple adder and iteration-counter environment.
module tb_cordic_ln_ctrl_fsm;

  localparam int ITERS = 25;

  logic CLK = 1'b0;
  logic RST, beg_FSM, ack_FSM;
  logic ACK_SUMX, ACK_SUMY, ACK_SUMZ;
  logic O_FX, O_FY, O_FZ, U_FX, U_FY, U_FZ;
  logic [4:0] CONT_ITERA;
  logic RST_DP, MS_1, MS_2, MS_3;
  logic EN_REG1X, EN_REG1Y, EN_REG1Z;
  logic EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4;
  logic Begin_SUMX, Begin_SUMY, Begin_SUMZ;
  logic ADD_SUBT, CLK_CDIR, ready, err;
  logic [17:0] outs;

  int checks = 0;
  int errors = 0;
  int ax, ay, az, cx, cy, cz;
  bit inj_ofy;
  int cyc;
  int n_bz, n_cd, n_r4, t_addbeg, gap;
  int lat;
  bit found;

  always #5 CLK = ~CLK;

  cordic_ln_ctrl_fsm #(.D(5), .ITERS(ITERS)) u_dut (
    .CLK(CLK), .RST(RST), .beg_FSM(beg_FSM), .ack_FSM(ack_FSM),
    .ACK_SUMX(ACK_SUMX), .ACK_SUMY(ACK_SUMY), .ACK_SUMZ(ACK_SUMZ),
    .O_FX(O_FX), .O_FY(O_FY), .O_FZ(O_FZ),
    .U_FX(U_FX), .U_FY(U_FY), .U_FZ(U_FZ),
    .CONT_ITERA(CONT_ITERA),
    .RST_DP(RST_DP), .MS_1(MS_1), .MS_2(MS_2), .MS_3(MS_3),
    .EN_REG1X(EN_REG1X), .EN_REG1Y(EN_REG1Y), .EN_REG1Z(EN_REG1Z),
    .EN_REG2(EN_REG2), .EN_REG2XYZ(EN_REG2XYZ),
    .EN_REG3(EN_REG3), .EN_REG4(EN_REG4),
    .Begin_SUMX(Begin_SUMX), .Begin_SUMY(Begin_SUMY),
    .Begin_SUMZ(Begin_SUMZ), .ADD_SUBT(ADD_SUBT),
    .CLK_CDIR(CLK_CDIR), .ready(ready), .err(err)
  );

  assign outs = {RST_DP, MS_1, MS_2, MS_3, EN_REG1X, EN_REG1Y,
                 EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4,
                 Begin_SUMX, Begin_SUMY, Begin_SUMZ, ADD_SUBT,
                 CLK_CDIR, ready, err};

  // Datapath iteration counter.
  always @(posedge CLK) begin
    if (RST || RST_DP) CONT_ITERA <= '0;
    else if (CLK_CDIR) CONT_ITERA <= CONT_ITERA + 5'd1;
  end

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Job latency from beg to ready for per-adder latencies x, y, z.
  function automatic int lat_exp(input int x, input int y, input int z);
    int mi;
    int ma;
    mi = max2(x, y);
    ma = max2(mi, z);
    return 3 + (mi + 2) + ITERS * (ma + 5) + (z + 2);
  endfunction

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then drive adder responses.
  // A latency of 0 means that adder never answers.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (Begin_SUMZ) n_bz++;
    if (CLK_CDIR) n_cd++;
    if (EN_REG4) n_r4++;
    if (Begin_SUMX && Begin_SUMZ && t_addbeg < 0) t_addbeg = cyc;
    if (EN_REG1X && !MS_1 && t_addbeg >= 0 && gap < 0)
      gap = cyc - t_addbeg;
    ACK_SUMX = 1'b0;
    ACK_SUMY = 1'b0;
    ACK_SUMZ = 1'b0;
    O_FY     = 1'b0;
    if (RST) begin
      cx = 0;
      cy = 0;
      cz = 0;
    end
    if (Begin_SUMX) cx = ax;
    else if (cx > 0) begin
      cx--;
      if (cx == 0) ACK_SUMX = 1'b1;
    end
    if (Begin_SUMY) cy = ay;
    else if (cy > 0) begin
      cy--;
      if (cy == 0) ACK_SUMY = 1'b1;
    end
    if (Begin_SUMZ) cz = az;
    else if (cz > 0) begin
      cz--;
      if (cz == 0) ACK_SUMZ = 1'b1;
    end
    if (ACK_SUMY && inj_ofy && CONT_ITERA == 5'd10) O_FY = 1'b1;
  endtask

  task automatic clr_stats();
    n_bz     = 0;
    n_cd     = 0;
    n_r4     = 0;
    t_addbeg = -1;
    gap      = -1;
  endtask

  // Starts a job from IDLE; l = cycles beg -> ready, -1 if budget ran out.
  task automatic run_job(input int budget, output int l);
    clr_stats();
    l = -1;
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    for (int i = 1; i < budget; i++) begin
      if (ready) begin
        l = i;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_job();
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
  endtask

  initial begin
    RST = 1'b1; beg_FSM = 1'b1; ack_FSM = 1'b0;
    ACK_SUMX = 1'b0; ACK_SUMY = 1'b0; ACK_SUMZ = 1'b0;
    O_FX = 1'b0; O_FY = 1'b0; O_FZ = 1'b0;
    U_FX = 1'b0; U_FY = 1'b0; U_FZ = 1'b0;
    ax = 4; ay = 4; az = 4; cx = 0; cy = 0; cz = 0;
    inj_ofy = 1'b0; cyc = 0;
    clr_stats();

    // Reset with beg_FSM held high
    tick();
    chk("rst_outs_c1", 32'(outs), 0);
    tick();
    chk("rst_outs_c2", 32'(outs), 0);
    RST = 1'b0;
    beg_FSM = 1'b0;
    tick();
    chk("idle_after_rst", 32'(outs), 0);

    // Nominal job, A=4
    run_job(400, lat);
    chk("nom_latency", lat, 240);
    chk("nom_begin_z", n_bz, ITERS + 1);
    chk("nom_clk_cdir", n_cd, ITERS - 1);
    chk("nom_en_reg4", n_r4, 1);
    chk("nom_add_gap", gap, 5);
    chk("nom_err", 32'(err), 0);
    beg_FSM = 1'b1;
    tick();
    chk("done_ignores_beg", 32'(ready), 1);
    chk("done_no_restart", 32'(RST_DP), 0);
    beg_FSM = 1'b0;
    ack_job();
    chk("ack_ready_low", 32'(ready), 0);
    tick();
    chk("ack_idle", 32'(outs), 0);

    // Staggered ACKs: X +2, Y +5, Z +3
    ax = 2; ay = 5; az = 3;
    run_job(600, lat);
    chk("stag_add_gap", gap, 6);
    chk("stag_latency", lat, lat_exp(2, 5, 3));
    ack_job();

    // Overflow on Y during iteration 10, then a clean job
    ax = 4; ay = 4; az = 4;
    inj_ofy = 1'b1;
    run_job(400, lat);
    chk("ovf_latency", lat, 240);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_en_reg4", n_r4, 1);
    ack_job();
    inj_ofy = 1'b0;
    run_job(400, lat);
    chk("clean_err", 32'(err), 0);
    ack_job();

    // Randomized adder latencies
    for (int j = 0; j < 4; j++) begin
      ax = int'($urandom_range(1, 7));
      ay = int'($urandom_range(1, 7));
      az = int'($urandom_range(1, 7));
      run_job(800, lat);
      chk("rnd_latency", lat, lat_exp(ax, ay, az));
      chk("rnd_begin_z", n_bz, ITERS + 1);
      chk("rnd_clk_cdir", n_cd, ITERS - 1);
      chk("rnd_err", 32'(err), 0);
      ack_job();
    end

    // Reset in ADD_WAIT of iteration 7
    ax = 4; ay = 4; az = 4;
    found = 1'b0;
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (Begin_SUMX && Begin_SUMZ && CONT_ITERA == 5'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_iter7", 32'(found), 1);
    tick();
    RST = 1'b1;
    tick();
    chk("midrst_outs", 32'(outs), 0);
    RST = 1'b0;
    clr_stats();
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_no_start", n_bz, 0);
    run_job(400, lat);
    chk("post_rst_latency", lat, 240);
    chk("post_rst_begin_z", n_bz, ITERS + 1);
    ack_job();

    // Z adder never answers
    ax = 4; ay = 4; az = 0;
`ifdef CORDIC_TIMEOUT_EN
    run_job(600, lat);
    chk("tmo_latency", lat, 3 + 6 + 3 + 255);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_en_reg4", n_r4, 0);
    ack_job();
`else
    run_job(400, lat);
    chk("hang_no_ready", lat, -1);
    chk("hang_begin_z", n_bz, 1);
    chk("hang_clk_cdir", n_cd, 0);
    chk("hang_en_reg4", n_r4, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("hang_rst_idle", 32'(outs), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
